// File: rtl/ysyx_25060170_ifu.sv
// Instruction fetch unit: IDLE -> REQ -> WAIT -> VALID fetch loop with a
// decoupled request/response memory port and a valid/ready decode handshake.
// Optional misaligned-redirect trap enabled by defining the macro
// YSYX_25060170_IFU_MISALIGN_CHK_EN (adds a sticky FAULT state); without it
// redirect targets are forced word-aligned and fault_o is tied low.
module ysyx_25060170_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  // Instruction memory request/response
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  // Decode-side handshake
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  // Writeback redirect for the consumed instruction
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault_o
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StWait  = 3'd2,
    StValid = 3'd3
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
    ,
    StFault = 3'd4
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] redirect_tgt;
  logic        redirect_bad;

`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
  // Keep the raw target so the faulting address stays visible on pc_o.
  always_comb begin
    redirect_tgt = redirect_pc;
    redirect_bad = |redirect_pc[1:0];
  end
`else
  // Low address bits are dropped; a misaligned target is silently aligned.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    redirect_tgt = {redirect_pc[31:2], 2'b00};
    redirect_bad = 1'b0;
  end
`endif

  // Next-state, next-PC and instruction latch decisions.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      StIdle: begin
        state_d = StReq;
      end
      StReq: begin
        // A response arriving in the acceptance cycle belongs to nobody.
        if (imem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = StValid;
        end
      end
      StValid: begin
        // Redirect only counts on the cycle the instruction is consumed.
        if (out_ready) begin
          state_d = StReq;
          if (redirect_valid) begin
            pc_d = redirect_tgt;
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
            if (redirect_bad) begin
              state_d = StFault;
            end
`endif
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
      StFault: begin
        state_d = StFault;
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // Moore outputs decoded from the current state and registers.
  always_comb begin
    imem_req_valid = (state_q == StReq);
    imem_addr      = pc_q;
    out_valid      = (state_q == StValid);
    pc_o           = pc_q;
    inst_o         = inst_q;
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
    fault_o        = (state_q == StFault);
`else
    fault_o        = 1'b0;
`endif
  end

  // redirect_bad is only consumed when the misalignment trap is built in.
  logic unused_redirect_bad;
  assign unused_redirect_bad = redirect_bad;

endmodule

// File: tb/tb_ysyx_25060170_ifu.sv
// Self-checking bench for ysyx_25060170_ifu: directed scenarios plus a
// randomized transaction loop checked against a fetch-sequence model.
module tb_ysyx_25060170_ifu;

  localparam logic [31:0] ResetPc = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault_o;

  int checks;
  int errors;

  ysyx_25060170_ifu #(
    .RESET_PC(ResetPc)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fault_o       (fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs are driven and outputs sampled 2 units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  // Leaves the DUT in IDLE with rst_n released.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // From REQ: zero-wait accept and respond, ending in VALID.
  task automatic fetch_to_valid(input logic [31:0] d);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = d;
    tick();
    imem_rsp_valid = 1'b0;
  endtask

  // From VALID: consume the instruction with an optional redirect.
  task automatic handshake(input logic rv, input logic [31:0] tgt);
    out_ready      = 1'b1;
    redirect_valid = rv;
    redirect_pc    = tgt;
    tick();
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = $urandom;
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1234_5678;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid);
    end
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL reset_req_valid got %0b want 0", imem_req_valid);
    end
    checks++;
    if (pc_o !== ResetPc) begin
      errors++; $display("FAIL reset_pc got %08h want %08h", pc_o, ResetPc);
    end
    checks++;
    if (inst_o !== 32'h0) begin
      errors++; $display("FAIL reset_inst got %08h want 0", inst_o);
    end
    checks++;
    if (fault_o !== 1'b0) begin
      errors++; $display("FAIL reset_fault got %0b want 0", fault_o);
    end
    rst_n = 1'b1;
    idle_inputs();
    checks++;
    if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_outputs got req=%0b out=%0b want 0 0", imem_req_valid, out_valid);
    end
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== ResetPc) begin
      errors++;
      $display("FAIL first_req got req=%0b addr=%08h want 1 %08h", imem_req_valid, imem_addr,
               ResetPc);
    end
  endtask

  task automatic test_stream();
    logic        exp_v;
    logic [31:0] exp_pc;
    do_reset();
    tick();
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    out_ready      = 1'b1;
    for (int k = 0; k < 9; k++) begin
      exp_v  = (k % 3 == 2);
      exp_pc = ResetPc + 32'(4 * (k / 3));
      checks++;
      if (out_valid !== exp_v || pc_o !== exp_pc) begin
        errors++;
        $display("FAIL stream_cycle%0d got valid=%0b pc=%08h want %0b %08h", k, out_valid, pc_o,
                 exp_v, exp_pc);
      end
      checks++;
      if (imem_req_valid !== (k % 3 == 0)) begin
        errors++;
        $display("FAIL stream_req%0d got %0b want %0b", k, imem_req_valid, (k % 3 == 0));
      end
      if (exp_v) begin
        checks++;
        if (inst_o !== 32'h0000_0013) begin
          errors++; $display("FAIL stream_inst%0d got %08h want 00000013", k, inst_o);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_req_stall();
    logic [31:0] d;
    do_reset();
    tick();
    for (int i = 0; i <= 5; i++) begin
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== ResetPc) begin
        errors++;
        $display("FAIL req_stall%0d got req=%0b addr=%08h want 1 %08h", i, imem_req_valid,
                 imem_addr, ResetPc);
      end
      imem_req_ready = (i == 5);
      tick();
    end
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL rsp_wait%0d got out=%0b req=%0b want 0 0", i, out_valid, imem_req_valid);
      end
      tick();
    end
    d = $urandom;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = d;
    tick();
    imem_rsp_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || inst_o !== d) begin
      errors++;
      $display("FAIL rsp_late got out=%0b inst=%08h want 1 %08h", out_valid, inst_o, d);
    end
  endtask

  task automatic test_out_stall_redirect();
    logic [31:0] d;
    do_reset();
    tick();
    d = $urandom;
    fetch_to_valid(d);
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || pc_o !== ResetPc || inst_o !== d || imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL out_stall%0d got v=%0b pc=%08h inst=%08h req=%0b want 1 %08h %08h 0", i,
                 out_valid, pc_o, inst_o, imem_req_valid, ResetPc, d);
      end
    end
    handshake(1'b1, 32'h8000_0100);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0100) begin
      errors++;
      $display("FAIL redirect_addr got req=%0b addr=%08h want 1 80000100", imem_req_valid,
               imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    fetch_to_valid($urandom);
    handshake(1'b1, 32'hFFFF_FFFC);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_setup got %08h want fffffffc", imem_addr);
    end
    fetch_to_valid($urandom);
    handshake(1'b0, 32'h0);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_addr got req=%0b addr=%08h want 1 00000000", imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    do_reset();
    tick();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc_o !== ResetPc) begin
      errors++;
      $display("FAIL mid_reset got out=%0b req=%0b pc=%08h want 0 0 %08h", out_valid,
               imem_req_valid, pc_o, ResetPc);
    end
    tick();
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== ResetPc ||
        inst_o !== 32'h0) begin
      errors++;
      $display("FAIL late_rsp got out=%0b req=%0b addr=%08h inst=%08h want 0 1 %08h 0",
               out_valid, imem_req_valid, imem_addr, inst_o, ResetPc);
    end
    d = $urandom;
    fetch_to_valid(d);
    checks++;
    if (out_valid !== 1'b1 || inst_o !== d || pc_o !== ResetPc) begin
      errors++;
      $display("FAIL post_reset_fetch got v=%0b inst=%08h pc=%08h want 1 %08h %08h", out_valid,
               inst_o, pc_o, d, ResetPc);
    end
    // Reset coincident with a redirecting handshake must win.
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0400;
    rst_n          = 1'b0;
    tick();
    rst_n = 1'b1;
    idle_inputs();
    checks++;
    if (pc_o !== ResetPc || out_valid !== 1'b0 || inst_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_priority got pc=%08h v=%0b inst=%08h want %08h 0 0", pc_o, out_valid,
               inst_o, ResetPc);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    tick();
    fetch_to_valid($urandom);
    handshake(1'b1, 32'h8000_0102);
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    out_ready      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fault_o !== 1'b1 || imem_req_valid !== 1'b0 || out_valid !== 1'b0 ||
          pc_o !== 32'h8000_0102) begin
        errors++;
        $display("FAIL fault_hold%0d got f=%0b req=%0b v=%0b pc=%08h want 1 0 0 80000102", i,
                 fault_o, imem_req_valid, out_valid, pc_o);
      end
      tick();
    end
    do_reset();
    checks++;
    if (fault_o !== 1'b0) begin
      errors++; $display("FAIL fault_clear got %0b want 0", fault_o);
    end
`else
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0100 || fault_o !== 1'b0) begin
      errors++;
      $display("FAIL misalign_align got req=%0b addr=%08h f=%0b want 1 80000100 0",
               imem_req_valid, imem_addr, fault_o);
    end
`endif
  endtask

  // Transaction-level model: each consumed instruction advances the PC by 4
  // (mod 2^32) or jumps to the word-aligned redirect target.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] tgt;
    logic        rv;
    int          rd;
    int          sd;
    int          os;
    do_reset();
    tick();
    exp_pc = ResetPc;
    for (int n = 0; n < 60; n++) begin
      rd = int'($urandom_range(0, 3));
      sd = int'($urandom_range(0, 3));
      os = int'($urandom_range(0, 2));
      for (int i = 0; i <= rd; i++) begin
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== exp_pc || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_req n%0d got req=%0b addr=%08h v=%0b want 1 %08h 0", n,
                   imem_req_valid, imem_addr, out_valid, exp_pc);
        end
        imem_req_ready = (i == rd);
        imem_rsp_valid = 1'($urandom_range(0, 1));
        imem_rsp_data  = $urandom;
        out_ready      = 1'($urandom_range(0, 1));
        redirect_valid = 1'($urandom_range(0, 1));
        redirect_pc    = $urandom;
        tick();
      end
      imem_req_ready = 1'b0;
      exp_inst       = $urandom;
      for (int i = 0; i <= sd; i++) begin
        checks++;
        if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 || pc_o !== exp_pc) begin
          errors++;
          $display("FAIL rand_wait n%0d got req=%0b v=%0b pc=%08h want 0 0 %08h", n,
                   imem_req_valid, out_valid, pc_o, exp_pc);
        end
        imem_rsp_valid = (i == sd);
        imem_rsp_data  = (i == sd) ? exp_inst : $urandom;
        out_ready      = 1'($urandom_range(0, 1));
        redirect_valid = 1'($urandom_range(0, 1));
        redirect_pc    = $urandom;
        tick();
      end
      for (int i = 0; i <= os; i++) begin
        checks++;
        if (out_valid !== 1'b1 || pc_o !== exp_pc || inst_o !== exp_inst ||
            imem_req_valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_valid n%0d got v=%0b pc=%08h inst=%08h want 1 %08h %08h", n,
                   out_valid, pc_o, inst_o, exp_pc, exp_inst);
        end
        rv = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       tgt = 32'hFFFF_FFF8;
          1:       tgt = 32'hFFFF_FFFC;
          default: tgt = $urandom;
        endcase
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
        tgt = tgt & 32'hFFFF_FFFC;
`endif
        out_ready      = (i == os);
        redirect_valid = rv;
        redirect_pc    = tgt;
        imem_rsp_valid = 1'($urandom_range(0, 1));
        imem_rsp_data  = $urandom;
        if (i == os) begin
          exp_pc = rv ? (tgt & 32'hFFFF_FFFC) : exp_pc + 32'd4;
        end
        tick();
      end
      idle_inputs();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_stream();
    test_req_stall();
    test_out_stall_redirect();
    test_wrap();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
